// File: rtl/btn_event_arbiter.sv
// ============================================================================
// btn_event_arbiter
// ----------------------------------------------------------------------------
// Turns N debounced button levels into one stream of press events for the
// matrix-calculator control FSM. Each button can have one pending press. The
// pending presses are granted round-robin over a valid/ready handshake.
//
// Ports
//   clk        in   1      system clock
//   rst        in   1      asynchronous, active-high reset
//   btn_lvl    in   N_BTN  debounced button levels, synchronous to clk
//   enable     in   1      1: accept new presses, 0: ignore new presses
//   evt_valid  out  1      event available
//   evt_ready  in   1      consumer accepts the event
//   evt_id     out  IDX_W  index of the pressed button
//   evt_rpt    out  1      1: auto-repeat event, 0: fresh press
//   pend       out  N_BTN  pending-press flags (status/debug)
//   ovf        out  1      sticky: a press was dropped; cleared only by rst
//
// Configuration macro
//   BTN_AUTOREPEAT_EN  when defined, each held button re-raises a request
//                      after HOLD_CYC cycles and then every REPEAT_CYC cycles.
//                      When undefined, there are no hold counters and evt_rpt
//                      stays 0.
// ============================================================================
module btn_event_arbiter #(
    parameter int N_BTN      = 5,
    parameter int IDX_W      = 3,
    parameter bit ACTIVE_LOW = 1'b0,
    parameter int HOLD_CYC   = 100_000_000,
    parameter int REPEAT_CYC = 20_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_lvl,
    input  logic             enable,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDX_W-1:0] evt_id,
    output logic             evt_rpt,
    output logic [N_BTN-1:0] pend,
    output logic             ovf
);

    // Reject parameter sets that the counters and the pointer cannot represent.
    if (N_BTN < 2 || N_BTN > 8 || (1 << IDX_W) < N_BTN ||
        REPEAT_CYC < 1 || REPEAT_CYC > HOLD_CYC || HOLD_CYC >= (1 << 27)) begin : g_bad_params
        $error("btn_event_arbiter: unsupported parameter combination");
    end

    logic [N_BTN-1:0] p;          // normalised level, 1 = pressed
    logic [N_BTN-1:0] prev;       // level seen on the previous edge
    logic [N_BTN-1:0] rpt;        // per-button "pending request is a repeat"
    logic [N_BTN-1:0] press;      // fresh press edges this cycle
    logic [N_BTN-1:0] rpt_req;    // auto-repeat requests this cycle
    logic [N_BTN-1:0] grant_oh;   // one-hot of the button granted this cycle
    logic [N_BTN-1:0] pend_nxt;
    logic [N_BTN-1:0] rpt_nxt;
    logic             armed;      // low on the first edge after reset
    logic             idle;
    logic             grant;
    logic             ovf_set;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] sel;

    assign p     = btn_lvl ^ {N_BTN{ACTIVE_LOW}};
    // A button held through reset is loaded into prev on the arming edge and
    // so never looks like a rising edge.
    assign press = {N_BTN{armed & enable}} & p & ~prev;
    assign idle  = !evt_valid || evt_ready;
    assign grant = idle && (|pend);

    // Round-robin pick: walk offsets from the far end down to 0 so the
    // closest set bit at or above rr_ptr (with wrap) is the one kept.
    always_comb begin : sel_search
        int j;
        // NOTE: every always_comb output gets a default before any branch;
        // a path that leaves it unassigned would infer a latch.
        sel = '0;
        j   = 0;
        for (int k = N_BTN - 1; k >= 0; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= N_BTN) j = j - N_BTN;
            if (pend[j]) sel = IDX_W'(j);
        end
    end

    assign grant_oh = grant ? (N_BTN'(1) << sel) : '0;

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [26:0] HOLD_L   = 27'(HOLD_CYC);
    localparam logic [26:0] RELOAD_L = 27'(HOLD_CYC - REPEAT_CYC);

    // hold_cnt counts edges since the press. On reaching HOLD_CYC it fires and
    // rewinds by REPEAT_CYC, so the next fire comes REPEAT_CYC edges later and
    // the count never approaches the 27-bit ceiling.
    logic [26:0] hold_cnt [N_BTN];
    logic [N_BTN-1:0] cnt_run;

    assign cnt_run = {N_BTN{armed & enable}} & p & ~press;

    always_comb begin
        rpt_req = '0;
        for (int i = 0; i < N_BTN; i++) begin
            rpt_req[i] = cnt_run[i] && (hold_cnt[i] + 27'd1 == HOLD_L);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) hold_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (!cnt_run[i])                hold_cnt[i] <= '0;
                else if (rpt_req[i])            hold_cnt[i] <= RELOAD_L;
                else if (hold_cnt[i] != '1)     hold_cnt[i] <= hold_cnt[i] + 27'd1;
            end
        end
    end
`else
    assign rpt_req = '0;
`endif

    // Pending-flag update. The grant clears first and a new request may set the
    // bit again, so a set on the grant edge wins. A fresh press onto a bit that
    // stays pending is dropped and flagged. A repeat onto one is simply merged.
    always_comb begin
        pend_nxt = pend & ~grant_oh;
        rpt_nxt  = rpt;
        ovf_set  = |(press & pend & ~grant_oh);
        for (int i = 0; i < N_BTN; i++) begin
            if (press[i]) begin
                pend_nxt[i] = 1'b1;
                rpt_nxt[i]  = 1'b0;
            end else if (rpt_req[i] && !(pend[i] && !grant_oh[i])) begin
                pend_nxt[i] = 1'b1;
                rpt_nxt[i]  = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev      <= '0;
            armed     <= 1'b0;
            pend      <= '0;
            rpt       <= '0;
            ovf       <= 1'b0;
            rr_ptr    <= '0;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_rpt   <= 1'b0;
        end else begin
            prev  <= p;
            armed <= 1'b1;
            pend  <= pend_nxt;
            rpt   <= rpt_nxt;
            if (ovf_set) ovf <= 1'b1;
            if (grant) begin
                evt_valid <= 1'b1;
                evt_id    <= sel;
                evt_rpt   <= rpt[sel];
                rr_ptr    <= (sel == IDX_W'(N_BTN - 1)) ? '0 : sel + IDX_W'(1);
            end else if (idle) begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_btn_event_arbiter.sv
// ============================================================================
// tb_btn_event_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for btn_event_arbiter. A cycle-level reference model
// built from the behavioural rules (pending set, round-robin search by
// distance, hold-time arithmetic) predicts every output after each clock
// edge. Directed scenarios are followed by a randomized phase with occasional
// asynchronous resets. Build with +define+BTN_AUTOREPEAT_EN to cover the
// auto-repeat feature.
// ============================================================================
module tb_btn_event_arbiter;

    localparam int N    = 5;
    localparam int IW   = 3;
    localparam int HOLD = 20;
    localparam int REP  = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  btn_lvl = '0;
    logic          enable = 1'b0;
    logic          evt_ready = 1'b0;
    logic          evt_valid;
    logic [IW-1:0] evt_id;
    logic          evt_rpt;
    logic [N-1:0]  pend;
    logic          ovf;

    always #5 clk = ~clk;

    btn_event_arbiter #(
        .N_BTN(N), .IDX_W(IW), .ACTIVE_LOW(1'b0), .HOLD_CYC(HOLD), .REPEAT_CYC(REP)
    ) dut (
        .clk(clk), .rst(rst), .btn_lvl(btn_lvl), .enable(enable),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
        .evt_rpt(evt_rpt), .pend(pend), .ovf(ovf)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_armed;
    bit [N-1:0]  m_prev;
    bit [N-1:0]  m_pend;
    bit [N-1:0]  m_rpt;
    bit          m_ovf;
    int          m_rr;
    bit          m_valid;
    int          m_id;
    bit          m_rpt_o;
    int          m_held [N];

    typedef struct { int id; bit rpt; } evt_t;
    evt_t dut_q[$];   // handshakes observed on the DUT port

    function automatic void model_reset();
        m_armed = 0; m_prev = '0; m_pend = '0; m_rpt = '0; m_ovf = 0;
        m_rr = 0; m_valid = 0; m_id = 0; m_rpt_o = 0;
        for (int i = 0; i < N; i++) m_held[i] = 0;
    endfunction

    function automatic void model_step(input bit [N-1:0] lvl, input bit en, input bit rdy);
        bit [N-1:0] pr;
        bit [N-1:0] old_pend;
        int         gi;
        bit         rep;
        old_pend = m_pend;
        for (int i = 0; i < N; i++) pr[i] = m_armed && en && lvl[i] && !m_prev[i];
        gi = -1;
        if (!m_valid || rdy) begin
            for (int d = 0; d < N; d++) begin
                if (gi < 0 && m_pend[(m_rr + d) % N]) gi = (m_rr + d) % N;
            end
            if (gi >= 0) begin
                m_valid = 1; m_id = gi; m_rpt_o = m_rpt[gi];
                m_pend[gi] = 0; m_rr = (gi + 1) % N;
            end else begin
                m_valid = 0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!m_armed || !lvl[i] || !en || pr[i]) m_held[i] = 0;
            else m_held[i]++;
`ifdef BTN_AUTOREPEAT_EN
            rep = (m_held[i] >= HOLD) && ((m_held[i] - HOLD) % REP == 0);
`else
            rep = 0;
`endif
            if (pr[i]) begin
                if (old_pend[i] && gi != i) m_ovf = 1;
                m_pend[i] = 1; m_rpt[i] = 0;
            end else if (rep && !(old_pend[i] && gi != i)) begin
                m_pend[i] = 1; m_rpt[i] = 1;
            end
        end
        m_prev = lvl;
        m_armed = 1;
    endfunction

    task automatic compare_all();
        check("evt_valid", evt_valid, m_valid);
        check("evt_id", evt_id, m_id);
        check("evt_rpt", evt_rpt, m_rpt_o);
        check("pend", pend, m_pend);
        check("ovf", ovf, m_ovf);
    endtask

    // One clock: log a handshake, advance the model at the edge, compare after.
    task automatic tick();
        evt_t e;
        if (!rst && evt_valid && evt_ready) begin
            e.id = int'(evt_id); e.rpt = evt_rpt;
            dut_q.push_back(e);
        end
        @(posedge clk);
        if (!rst) model_step(btn_lvl, enable, evt_ready);
        @(negedge clk);
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive(input logic [N-1:0] b, input logic en, input logic rdy);
        btn_lvl = b; enable = en; evt_ready = rdy;
    endtask

    // Called at a negedge; reset asserted between edges.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1 model_reset();
        compare_all();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n_id0;
        int exp_n;
        // Held button through reset must not produce a press.
        drive(5'b00100, 1'b1, 1'b1);
        #1 model_reset();
        compare_all();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        ticks(10);
        check("held_thru_rst_valid", evt_valid, 0);
        check("held_thru_rst_pend", pend, 0);
        check("held_thru_rst_events", dut_q.size(), 0);

        // Single press latency: pend after k, valid/id after k+1, idle after k+2.
        drive(5'b00000, 1'b1, 1'b1); tick();
        drive(5'b00100, 1'b1, 1'b1); tick();
        check("lat_pend_k", pend, 5'b00100);
        check("lat_valid_k", evt_valid, 0);
        tick();
        check("lat_valid_k1", evt_valid, 1);
        check("lat_id_k1", evt_id, 2);
        tick();
        check("lat_valid_k2", evt_valid, 0);

        // Bring rr_ptr to 2 by granting button 1, then a three-way press.
        drive(5'b00000, 1'b1, 1'b1); tick();
        drive(5'b00010, 1'b1, 1'b1); ticks(3);
        drive(5'b00000, 1'b1, 1'b0); tick();
        dut_q.delete();
        drive(5'b11010, 1'b1, 1'b0); ticks(2);
        check("rr_first_id", evt_id, 3);
        ticks(3);
        check("rr_stall_id", evt_id, 3);
        check("rr_stall_valid", evt_valid, 1);
        drive(5'b11010, 1'b1, 1'b1); ticks(4);
        check("rr_count", dut_q.size(), 3);
        if (dut_q.size() == 3) begin
            check("rr_order0", dut_q[0].id, 3);
            check("rr_order1", dut_q[1].id, 4);
            check("rr_order2", dut_q[2].id, 1);
        end

        // Overflow: re-press button 0 while its press is still pending.
        drive(5'b00000, 1'b1, 1'b0);
        do_reset();
        tick();
        drive(5'b01000, 1'b1, 1'b0); ticks(2);
        drive(5'b01001, 1'b1, 1'b0); tick();
        drive(5'b01000, 1'b1, 1'b0); tick();
        check("ovf_before", ovf, 0);
        drive(5'b01001, 1'b1, 1'b0); tick();
        check("ovf_set", ovf, 1);
        dut_q.delete();
        drive(5'b00000, 1'b1, 1'b1); ticks(4);
        n_id0 = 0;
        foreach (dut_q[i]) if (dut_q[i].id == 0) n_id0++;
        check("ovf_one_evt0", n_id0, 1);
        check("ovf_sticky", ovf, 1);

        // enable=0 blocks presses; re-enabling while held does not create one.
        dut_q.delete();
        drive(5'b00000, 1'b0, 1'b1); tick();
        drive(5'b00010, 1'b0, 1'b1); ticks(2);
        check("dis_pend", pend, 0);
        drive(5'b00010, 1'b1, 1'b1); ticks(3);
        check("dis_reen_events", dut_q.size(), 0);
        drive(5'b00000, 1'b1, 1'b1); tick();
        drive(5'b00010, 1'b1, 1'b1); ticks(2);
        check("dis_new_valid", evt_valid, 1);
        check("dis_new_id", evt_id, 1);

        // Long hold of button 4.
        drive(5'b00000, 1'b1, 1'b1);
        do_reset();
        ticks(2);
        dut_q.delete();
        drive(5'b10000, 1'b1, 1'b1); ticks(40);
        drive(5'b00000, 1'b1, 1'b1); ticks(3);
`ifdef BTN_AUTOREPEAT_EN
        exp_n = 5;
`else
        exp_n = 1;
`endif
        check("hold_events", dut_q.size(), exp_n);
        foreach (dut_q[i]) begin
            check("hold_id", dut_q[i].id, 4);
            check("hold_rpt", dut_q[i].rpt, (i == 0) ? 0 : 1);
        end

        // Randomized phase.
        for (int c = 0; c < 2000; c++) begin
            logic [N-1:0] b;
            b = btn_lvl;
            if ($urandom_range(0, 5) == 0) b[$urandom_range(0, N - 1)] ^= 1'b1;
            drive(b, ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 399) == 0) do_reset();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
